asrv32_fetch: RTL and testbench

- Instruction-fetch (IF) stage of the asrv32 pipeline; the producing end of the IF/ID interface.
- Owns the PC and runs a single-outstanding request/ack handshake to instruction memory.
- Presents instruction, PC and clock-enable to the decode stage and obeys its backward stall.
- Takes PC redirects from the ALU (branch/jump) and writeback (trap/mret). Holds a one-entry skid buffer so no acked instruction is lost under stall.

---
 rtl/asrv32_fetch_pkg.sv | 19 +
 rtl/asrv32_fetch.sv | 144 ++++++++++++++
 tb/tb_asrv32_fetch.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/asrv32_fetch_pkg.sv
// Shared definitions for the asrv32 instruction-fetch stage:
// FSM state encodings, PC step and PC alignment helper.
package asrv32_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE     = 2'd0,
        FETCH_WAIT_ACK = 2'd1,
        FETCH_HOLD     = 2'd2,
        FETCH_DISCARD  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] PC_INCR = 32'd4;

    // Instructions are word aligned; the two low target bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/asrv32_fetch.sv
// asrv32 IF stage: owns the PC, runs a single-outstanding request/ack fetch,
// feeds decode through a one-entry skid buffer and follows ALU/WB redirects.
module asrv32_fetch
    import asrv32_fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [31:0] o_iaddr,
    output logic        o_stb_inst,
    input  logic        i_ack_inst,
    input  logic [31:0] i_inst,
    input  logic        i_alu_change_pc,
    input  logic [31:0] i_alu_next_pc,
    input  logic        i_wb_change_pc,
    input  logic [31:0] i_wb_next_pc,
    output logic [31:0] o_inst_ifid,
    output logic [31:0] o_pc_ifid,
    output logic        o_ce,
    input  logic        i_stall
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  iaddr_q;
    logic         stb_q;
    logic [31:0]  inst_q;
    logic [31:0]  pc_ifid_q;
    logic         ce_q;
    logic [31:0]  skid_inst_q;
    logic [31:0]  skid_pc_q;

    logic         redirect;
    logic         ack;
    logic [31:0]  redirect_pc_d;
    logic [31:0]  pc_inc_d;

    // An ack only counts while a request is actually outstanding.
    assign ack = i_ack_inst & stb_q;

    always_comb begin
        redirect      = i_wb_change_pc | i_alu_change_pc;
        redirect_pc_d = align_pc(i_wb_change_pc ? i_wb_next_pc : i_alu_next_pc);
        pc_inc_d      = pc_q + PC_INCR;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= FETCH_IDLE;
            pc_q        <= PC_RESET;
            iaddr_q     <= PC_RESET;
            stb_q       <= 1'b0;
            inst_q      <= 32'd0;
            pc_ifid_q   <= 32'd0;
            ce_q        <= 1'b0;
            skid_inst_q <= 32'd0;
            skid_pc_q   <= 32'd0;
        end else if (redirect) begin
            pc_q        <= redirect_pc_d;
            ce_q        <= 1'b0;
            skid_inst_q <= 32'd0;
            skid_pc_q   <= 32'd0;
            case (state_q)
                FETCH_IDLE: begin
                    state_q <= FETCH_IDLE;
                    stb_q   <= 1'b0;
                end
                FETCH_WAIT_ACK: begin
                    if (ack) begin
                        state_q <= FETCH_WAIT_ACK;
                        iaddr_q <= redirect_pc_d;
                    end else begin
                        // Outstanding request must still complete; its data is dropped.
                        state_q <= FETCH_DISCARD;
                    end
                    stb_q <= 1'b1;
                end
                FETCH_HOLD: begin
                    state_q <= FETCH_WAIT_ACK;
                    iaddr_q <= redirect_pc_d;
                    stb_q   <= 1'b1;
                end
                default: begin
                    state_q <= FETCH_DISCARD;
                    stb_q   <= 1'b1;
                end
            endcase
        end else begin
            case (state_q)
                FETCH_IDLE: begin
                    if (!i_stall) begin
                        state_q <= FETCH_WAIT_ACK;
                        iaddr_q <= pc_q;
                        stb_q   <= 1'b1;
                        ce_q    <= 1'b0;
                    end
                end
                FETCH_WAIT_ACK: begin
                    if (ack && !i_stall) begin
                        inst_q    <= i_inst;
                        pc_ifid_q <= pc_q;
                        ce_q      <= 1'b1;
                        pc_q      <= pc_inc_d;
                        iaddr_q   <= pc_inc_d;
                    end else if (ack) begin
                        skid_inst_q <= i_inst;
                        skid_pc_q   <= pc_q;
                        pc_q        <= pc_inc_d;
                        state_q     <= FETCH_HOLD;
                        stb_q       <= 1'b0;
                    end else if (!i_stall) begin
                        ce_q <= 1'b0;
                    end
                end
                FETCH_HOLD: begin
                    if (!i_stall) begin
                        inst_q      <= skid_inst_q;
                        pc_ifid_q   <= skid_pc_q;
                        ce_q        <= 1'b1;
                        skid_inst_q <= 32'd0;
                        skid_pc_q   <= 32'd0;
                        state_q     <= FETCH_WAIT_ACK;
                        iaddr_q     <= pc_q;
                        stb_q       <= 1'b1;
                    end
                end
                default: begin
                    if (ack) begin
                        state_q <= FETCH_WAIT_ACK;
                        iaddr_q <= pc_q;
                    end
                end
            endcase
        end
    end

    assign o_iaddr     = iaddr_q;
    assign o_stb_inst  = stb_q;
    assign o_inst_ifid = inst_q;
    assign o_pc_ifid   = pc_ifid_q;
    assign o_ce        = ce_q;

endmodule

// File: tb/tb_asrv32_fetch.sv
// Directed bench for asrv32_fetch: each step drives inputs, takes one clock
// edge and compares registered outputs against hand-computed values.
module tb_asrv32_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] iaddr;
    logic        stb;
    logic        ack;
    logic [31:0] inst;
    logic        alu_c;
    logic [31:0] alu_pc;
    logic        wb_c;
    logic [31:0] wb_pc;
    logic [31:0] inst_ifid;
    logic [31:0] pc_ifid;
    logic        ce;
    logic        stall;
    logic        auto_inst;

    int errors = 0;
    int checks = 0;

    asrv32_fetch #(.PC_RESET(32'h0000_0000)) dut (
        .i_clk(clk), .i_rst(rst),
        .o_iaddr(iaddr), .o_stb_inst(stb),
        .i_ack_inst(ack), .i_inst(inst),
        .i_alu_change_pc(alu_c), .i_alu_next_pc(alu_pc),
        .i_wb_change_pc(wb_c), .i_wb_next_pc(wb_pc),
        .o_inst_ifid(inst_ifid), .o_pc_ifid(pc_ifid), .o_ce(ce),
        .i_stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Memory returns a word tagged with its address unless a test overrides i_inst.
    task automatic cyc();
        if (auto_inst) inst = 32'hA000_0000 | iaddr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ack = 1'b0; inst = 32'd0; alu_c = 1'b0; alu_pc = 32'd0;
        wb_c = 1'b0; wb_pc = 32'd0; stall = 1'b0; auto_inst = 1'b1;
        cyc(); cyc();
        chk("rst_iaddr", iaddr, 32'h0);
        chk("rst_stb", {31'd0, stb}, 32'd0);
        chk("rst_ce", {31'd0, ce}, 32'd0);
        chk("rst_inst", inst_ifid, 32'd0);
        chk("rst_pc", pc_ifid, 32'd0);

        // Zero-wait memory: one instruction per cycle.
        rst = 1'b0; ack = 1'b1;
        cyc();
        chk("zw_first_stb", {31'd0, stb}, 32'd1);
        chk("zw_first_ce", {31'd0, ce}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("zw_pc", pc_ifid, 32'(4 * k));
            chk("zw_inst", inst_ifid, 32'hA000_0000 | 32'(4 * k));
            chk("zw_ce", {31'd0, ce}, 32'd1);
        end
        chk("zw_iaddr", iaddr, 32'h10);

        // Redirect coinciding with an ack drops the data and fetches the target.
        alu_c = 1'b1; alu_pc = 32'h100;
        cyc();
        alu_c = 1'b0;
        chk("rd_ack_iaddr", iaddr, 32'h100);
        chk("rd_ack_ce", {31'd0, ce}, 32'd0);
        chk("rd_ack_pc", pc_ifid, 32'hC);

        // Ack delayed three cycles at 0x100.
        ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("wait_iaddr", iaddr, 32'h100);
            chk("wait_stb", {31'd0, stb}, 32'd1);
            chk("wait_ce", {31'd0, ce}, 32'd0);
        end
        ack = 1'b1;
        cyc();
        chk("wait_done_pc", pc_ifid, 32'h100);
        chk("wait_done_ce", {31'd0, ce}, 32'd1);
        chk("wait_done_iaddr", iaddr, 32'h104);

        // Stall on the same cycle as the ack of 0x00A00093 at pc 0x8.
        alu_c = 1'b1; alu_pc = 32'h8;
        cyc();
        alu_c = 1'b0;
        chk("to8_iaddr", iaddr, 32'h8);
        auto_inst = 1'b0; inst = 32'h00A0_0093; stall = 1'b1;
        cyc();
        chk("hold_stb", {31'd0, stb}, 32'd0);
        chk("hold_pc", pc_ifid, 32'h100);
        chk("hold_inst", inst_ifid, 32'hA000_0100);
        inst = 32'h1111_1111;
        cyc();
        chk("hold2_stb", {31'd0, stb}, 32'd0);
        chk("hold2_ce", {31'd0, ce}, 32'd0);
        stall = 1'b0; ack = 1'b0; auto_inst = 1'b1;
        cyc();
        chk("rel_inst", inst_ifid, 32'h00A0_0093);
        chk("rel_pc", pc_ifid, 32'h8);
        chk("rel_ce", {31'd0, ce}, 32'd1);
        chk("rel_iaddr", iaddr, 32'hC);
        chk("rel_stb", {31'd0, stb}, 32'd1);

        // Redirect to 0x40 while 0x10 is outstanding: DISCARD path.
        ack = 1'b1;
        cyc();
        chk("c_pc", pc_ifid, 32'hC);
        chk("c_iaddr", iaddr, 32'h10);
        ack = 1'b0; alu_c = 1'b1; alu_pc = 32'h40;
        cyc();
        alu_c = 1'b0;
        chk("dis_iaddr", iaddr, 32'h10);
        chk("dis_stb", {31'd0, stb}, 32'd1);
        chk("dis_ce", {31'd0, ce}, 32'd0);
        cyc();
        chk("dis2_iaddr", iaddr, 32'h10);
        ack = 1'b1; auto_inst = 1'b0; inst = 32'hDEAD_BEEF;
        cyc();
        auto_inst = 1'b1;
        chk("dis_drop_iaddr", iaddr, 32'h40);
        chk("dis_drop_ce", {31'd0, ce}, 32'd0);
        chk("dis_drop_pc", pc_ifid, 32'hC);
        chk("dis_drop_inst", inst_ifid, 32'hA000_000C);
        ack = 1'b0;
        cyc();
        chk("dis_gap_ce", {31'd0, ce}, 32'd0);
        ack = 1'b1;
        cyc();
        chk("t40_pc", pc_ifid, 32'h40);
        chk("t40_ce", {31'd0, ce}, 32'd1);

        // Both redirects: writeback wins; then an unaligned target.
        alu_c = 1'b1; alu_pc = 32'h40; wb_c = 1'b1; wb_pc = 32'h80;
        cyc();
        alu_c = 1'b0;
        chk("both_iaddr", iaddr, 32'h80);
        wb_pc = 32'h83;
        cyc();
        wb_c = 1'b0;
        chk("align_iaddr", iaddr, 32'h80);
        cyc();
        chk("align_pc", pc_ifid, 32'h80);
        chk("align_inst", inst_ifid, 32'hA000_0080);
        chk("align_next", iaddr, 32'h84);

        // PC wrap at the top of the address space.
        wb_c = 1'b1; wb_pc = 32'hFFFF_FFFC;
        cyc();
        wb_c = 1'b0;
        chk("wrap_iaddr0", iaddr, 32'hFFFF_FFFC);
        cyc();
        chk("wrap_pc", pc_ifid, 32'hFFFF_FFFC);
        chk("wrap_iaddr", iaddr, 32'h0);

        // Reset in the middle of an outstanding request.
        ack = 1'b0; rst = 1'b1;
        cyc();
        chk("mid_rst_stb", {31'd0, stb}, 32'd0);
        chk("mid_rst_ce", {31'd0, ce}, 32'd0);
        chk("mid_rst_pc", pc_ifid, 32'd0);
        chk("mid_rst_inst", inst_ifid, 32'd0);
        rst = 1'b0; ack = 1'b1; stall = 1'b1;
        cyc();
        chk("late_ack_stb", {31'd0, stb}, 32'd0);
        chk("late_ack_inst", inst_ifid, 32'd0);
        stall = 1'b0; ack = 1'b0;
        cyc();
        chk("restart_stb", {31'd0, stb}, 32'd1);
        chk("restart_iaddr", iaddr, 32'h0);
        ack = 1'b1;
        cyc();
        chk("restart_pc", pc_ifid, 32'h0);
        chk("restart_ce", {31'd0, ce}, 32'd1);

        // Stall while a valid instruction is presented: outputs hold, skid catches 0x4.
        stall = 1'b1;
        cyc();
        chk("sk_hold_ce", {31'd0, ce}, 32'd1);
        chk("sk_hold_pc", pc_ifid, 32'h0);
        chk("sk_hold_stb", {31'd0, stb}, 32'd0);
        stall = 1'b0; ack = 1'b0;
        cyc();
        chk("sk_rel_pc", pc_ifid, 32'h4);
        chk("sk_rel_inst", inst_ifid, 32'hA000_0004);
        chk("sk_rel_iaddr", iaddr, 32'h8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
